// File: rtl/seg_pkg.sv
// Seven-segment encoding shared by the scan driver: active-low {g,f,e,d,c,b,a} hex glyphs.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_HEX [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/seg_hex_lut.sv
// Combinational hex nibble to active-low segment pattern.
module seg_hex_lut
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with per-slot dead time.
// Define SEVEN_SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seven_seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic                      load,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  output logic [6:0]                seg_n,
  output logic                      dp_n,
  output logic [NUM_DIGITS-1:0]     an_n,
  output logic                      frame_tick
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  logic [CW-1:0]           div_cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow_value;
  logic [NUM_DIGITS-1:0]   shadow_en;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_keep;

  logic [3:0] nibbles [NUM_DIGITS];
  logic [3:0] cur_nibble;
  logic [6:0] cur_seg;
  logic       div_wrap;
  logic       idx_last;
  logic       digit_on;

  always_comb begin
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      nibbles[k] = shadow_value[4*k +: 4];
    end
  end

  assign cur_nibble = nibbles[idx];

  seg_hex_lut u_lut (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  assign div_wrap = (div_cnt == CW'(SCAN_DIV - 1));
  assign idx_last = (idx == IW'(NUM_DIGITS - 1));
  assign digit_on = shadow_en[idx] & shadow_keep[idx] & (div_cnt >= CW'(GUARD_CYCLES));

`ifdef SEVEN_SEG_SCAN_LZB_EN
  // Digit k stays visible if any nibble at or above k is non-zero; digit 0 always stays.
  logic [NUM_DIGITS-1:0] keep_d;
  always_comb begin
    logic seen;
    seen   = 1'b0;
    keep_d = '0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      seen      = seen | (value[4*k +: 4] != 4'd0);
      keep_d[k] = seen | (k == 0);
    end
  end
`else
  assign shadow_keep = '1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt      <= '0;
      idx          <= '0;
      shadow_value <= '0;
      shadow_en    <= '0;
      shadow_dp    <= '0;
`ifdef SEVEN_SEG_SCAN_LZB_EN
      shadow_keep  <= '0;
`endif
      seg_n        <= SEG_BLANK;
      dp_n         <= 1'b1;
      an_n         <= '1;
      frame_tick   <= 1'b0;
    end else begin
      if (div_wrap) begin
        div_cnt <= '0;
        idx     <= idx_last ? '0 : idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      frame_tick <= div_wrap & idx_last;

      if (load) begin
        shadow_value <= value;
        shadow_en    <= digit_en;
        shadow_dp    <= dp_in;
`ifdef SEVEN_SEG_SCAN_LZB_EN
        shadow_keep  <= keep_d;
`endif
      end

      if (digit_on) begin
        an_n  <= ~(NUM_DIGITS'(1) << idx);
        seg_n <= cur_seg;
        dp_n  <= ~shadow_dp[idx];
      end else begin
        an_n  <= '1;
        seg_n <= SEG_BLANK;
        dp_n  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver: vector table, corner sequences, random vs model.
module tb_seven_seg_scan_driver;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int G  = 2;
`ifdef SEVEN_SEG_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  digit_en;
  logic [3:0]  dp_in;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .GUARD_CYCLES (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .digit_en   (digit_en),
    .dp_in      (dp_in),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: shadow contents plus cycles elapsed since reset.
  logic [15:0] m_val;
  logic [3:0]  m_en;
  logic [3:0]  m_dp;
  int          m_n;
  int          shown_n;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h18;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic bit m_keep(input int k);
    return !LZB || (k == 0) || ((m_val >> (4 * k)) != 16'd0);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_an;
    logic       e_ft;
    int         d;
    int         i;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    e_an  = 4'hF;
    e_ft  = 1'b0;
    if (!rst) begin
      d = m_n % SD;
      i = (m_n / SD) % ND;
      if (d >= G && m_en[i] && m_keep(i)) begin
        e_an[i] = 1'b0;
        e_seg   = ref_seg(m_val[4*i +: 4]);
        e_dp    = ~m_dp[i];
      end
      e_ft = ((m_n + 1) % (SD * ND)) == 0;
    end
    @(posedge clk);
    if (rst) begin
      shown_n = -1;
      m_n     = 0;
      m_val   = '0;
      m_en    = '0;
      m_dp    = '0;
    end else begin
      shown_n = m_n;
      m_n++;
      if (load) begin
        m_val = value;
        m_en  = digit_en;
        m_dp  = dp_in;
      end
    end
    #1;
    check("seg_n", int'(seg_n), int'(e_seg));
    check("dp_n", int'(dp_n), int'(e_dp));
    check("an_n", int'(an_n), int'(e_an));
    check("frame_tick", int'(frame_tick), int'(e_ft));
    check("an_onehot", int'($countones(~an_n) <= 1), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] e, input logic [3:0] p);
    value    = v;
    digit_en = e;
    dp_in    = p;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  // Advance until the outputs reflect slot k at divider position d.
  task automatic run_to(input int k, input int d);
    int budget;
    budget = 0;
    while (!(shown_n >= 0 && shown_n % SD == d && (shown_n / SD) % ND == k)) begin
      tick();
      budget++;
      if (budget > 200) begin
        check("run_to_timeout", 0, 1);
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] v;
    logic [3:0]  en;
    logic [3:0]  dp;
    int          k;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dpn;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int ft_cnt;
    int ft_last;
    int cyc;

    vecs[0] = '{16'h12AF, 4'hF,    4'h0,    0, 7'h0E, 4'b1110, 1'b1};
    vecs[1] = '{16'h12AF, 4'hF,    4'h0,    1, 7'h08, 4'b1101, 1'b1};
    vecs[2] = '{16'h12AF, 4'hF,    4'h0,    2, 7'h24, 4'b1011, 1'b1};
    vecs[3] = '{16'h12AF, 4'hF,    4'h0,    3, 7'h79, 4'b0111, 1'b1};
    vecs[4] = '{16'h12AF, 4'b1011, 4'b0010, 1, 7'h08, 4'b1101, 1'b0};
    vecs[5] = '{16'h12AF, 4'b1011, 4'b0010, 2, 7'h7F, 4'b1111, 1'b1};
    vecs[6] = '{16'h12AF, 4'b1011, 4'b0010, 3, 7'h79, 4'b0111, 1'b1};
    vecs[7] = '{16'h8D6B, 4'hF,    4'b1000, 3, 7'h00, 4'b0111, 1'b0};
    vecs[8] = '{16'h8D6B, 4'hF,    4'b1000, 0, 7'h03, 4'b1110, 1'b1};

    rst      = 1'b1;
    load     = 1'b0;
    value    = '0;
    digit_en = '0;
    dp_in    = '0;
    m_val    = '0;
    m_en     = '0;
    m_dp     = '0;
    m_n      = 0;
    shown_n  = -1;

    do_reset();
    check("reset_an", int'(an_n), 'hF);
    check("reset_seg", int'(seg_n), 'h7F);

    for (int v = 0; v < 9; v++) begin
      do_reset();
      do_load(vecs[v].v, vecs[v].en, vecs[v].dp);
      run_to(vecs[v].k, G - 1);
      check("vec_guard_an", int'(an_n), 'hF);
      run_to(vecs[v].k, G);
      check("vec_seg", int'(seg_n), int'(vecs[v].seg));
      check("vec_an", int'(an_n), int'(vecs[v].an));
      check("vec_dp", int'(dp_n), int'(vecs[v].dpn));
    end

    // Frame pulse spacing.
    do_reset();
    do_load(16'h12AF, 4'hF, 4'h0);
    ft_cnt  = 0;
    ft_last = -1;
    for (cyc = 0; cyc < 70; cyc++) begin
      tick();
      if (frame_tick) begin
        if (ft_last >= 0) check("frame_period", cyc - ft_last, SD * ND);
        ft_last = cyc;
        ft_cnt++;
      end
    end
    check("frame_count", ft_cnt, 2);

    // Reset in the middle of slot 2.
    do_reset();
    do_load(16'h12AF, 4'hF, 4'h0);
    run_to(2, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_an", int'(an_n), 'hF);
    check("midrst_seg", int'(seg_n), 'h7F);
    run_to(0, G);
    check("postrst_blank_an", int'(an_n), 'hF);
    do_load(16'h0000, 4'hF, 4'h0);
    run_to(0, G);
    check("postrst_seg0", int'(seg_n), 'h40);
    check("postrst_an0", int'(an_n), 'b1110);

    // Load on the slot-wrap edge.
    do_reset();
    do_load(16'h12AF, 4'hF, 4'h0);
    run_to(0, SD - 2);
    do_load(16'hFFFF, 4'hF, 4'h0);
    run_to(1, G - 1);
    check("wrapload_guard", int'(an_n), 'hF);
    tick();
    check("wrapload_seg", int'(seg_n), 'h0E);
    check("wrapload_an", int'(an_n), 'b1101);

    // Leading zeros.
    do_reset();
    do_load(16'h0005, 4'hF, 4'h0);
    run_to(0, G);
    check("lz_d0_seg", int'(seg_n), 'h12);
    run_to(1, G);
    check("lz_d1_an", int'(an_n), LZB ? 'hF : 'b1101);
    run_to(3, G);
    check("lz_d3_seg", int'(seg_n), LZB ? 'h7F : 'h40);
    do_load(16'h0000, 4'hF, 4'h0);
    run_to(0, G);
    check("lz0_d0_seg", int'(seg_n), 'h40);
    run_to(2, G);
    check("lz0_d2_an", int'(an_n), LZB ? 'hF : 'b1011);

    // Random traffic against the model.
    do_reset();
    for (int r = 0; r < 400; r++) begin
      value    = 16'($urandom);
      digit_en = 4'($urandom);
      dp_in    = 4'($urandom);
      load     = ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst  = 1'b0;
    load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
